// File: rtl/di2stream_pkg.sv
// di2stream_pkg: stream dtype codes shared by the playback path and its bench
package di2stream_pkg;
  localparam int DTYPE_WIDTH = 4;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'd1;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END = 4'd2;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START = 4'd3;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END = 4'd4;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL = 4'd5;
endpackage

// File: rtl/di2stream_ram.sv
// di2stream_ram: two-bank simple dual-port RAM, addresses are {bank, word}
module di2stream_ram #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH:0]   waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH:0]   raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**(ADDR_WIDTH+1)];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/di2stream.sv
// di2stream: replays host-written ping-pong frame banks as an image stream
module di2stream
  import di2stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 22,
  parameter int DI_DATA_WIDTH = 32,
  parameter int STREAM_DATA_WIDTH = 16,
  parameter int PIXEL_WIDTH = 10,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         resetb,
  input  logic                         enable,
  input  logic [15:0]                  num_cols,
  input  logic [15:0]                  num_rows,
  input  logic                         di_write_mode,
  input  logic                         di_write,
  input  logic [DI_DATA_WIDTH-1:0]     di_reg_datai,
  output logic                         di_write_rdy,
  output logic                         overflow,
  output logic                         dvo,
  output logic [DTYPE_WIDTH-1:0]       dtypeo,
  output logic [PIXEL_WIDTH-1:0]       datao,
  output logic [STREAM_DATA_WIDTH-1:0] meta_datao,
  output logic [15:0]                  frame_count
);
  localparam int H = DI_DATA_WIDTH / 2;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_WRITING} w_state_t;
  typedef enum logic [2:0] {S_IDLE, S_FS, S_RS, S_PIX, S_RE, S_FE, S_BLANK} s_state_t;
  w_state_t ws;
  s_state_t ss;
  logic wbuf, rbuf, wr_try, we;
  logic [1:0] full, set_m, clr_m;
  logic [ADDR_WIDTH:0] waddr;
  logic [1:0][ADDR_WIDTH:0] wcount;
  logic [15:0] cols, rows, row, col, blank;
  logic [31:0] rptr, ridx;
  logic [DI_DATA_WIDTH-1:0] rdata;
  logic [H-1:0] half;
  logic [PIXEL_WIDTH-1:0] pix;
  assign wr_try = ws == W_WRITING && di_write_mode && di_write && di_write_rdy;
  assign we = wr_try && !waddr[ADDR_WIDTH];
  assign set_m = (ws == W_WRITING && !di_write_mode) ? 2'b01 << wbuf : 2'b00;
  assign clr_m = ss == S_FE ? 2'b01 << rbuf : 2'b00;
  // look one word ahead on the high half so the next low half reads without a bubble
  assign ridx = (ss == S_PIX && col[0]) ? rptr + 32'd1 : rptr;
  assign half = col[0] ? rdata[DI_DATA_WIDTH-1:H] : rdata[H-1:0];
  assign pix = rptr < 32'(wcount[rbuf]) ? PIXEL_WIDTH'(half) : '0;
  di2stream_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DI_DATA_WIDTH)) u_ram (
    .clk(clk),
    .we(we),
    .waddr({wbuf, waddr[ADDR_WIDTH-1:0]}),
    .wdata(di_reg_datai),
    .raddr({rbuf, ADDR_WIDTH'(ridx)}),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) full <= '0;
    else if (!enable) full <= '0;
    else full <= (full | set_m) & ~clr_m;
  end
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      ws <= W_IDLE;
      wbuf <= 1'b0;
      waddr <= '0;
      wcount <= '0;
      di_write_rdy <= 1'b0;
      overflow <= 1'b0;
    end else if (!enable) begin
      ws <= W_IDLE;
      wbuf <= 1'b0;
      waddr <= '0;
      wcount <= '0;
      di_write_rdy <= 1'b0;
    end else begin
      case (ws)
        W_IDLE: if (di_write_mode) begin
          waddr <= '0;
          ws <= full[wbuf] ? W_WAIT : W_WRITING;
          di_write_rdy <= !full[wbuf];
        end
        W_WAIT: if (!di_write_mode) ws <= W_IDLE;
          else if (!full[wbuf]) begin
            ws <= W_WRITING;
            di_write_rdy <= 1'b1;
          end
        W_WRITING: if (!di_write_mode) begin
          wcount[wbuf] <= waddr;
          wbuf <= !wbuf;
          di_write_rdy <= 1'b0;
          ws <= W_IDLE;
        end else if (wr_try) begin
          if (waddr[ADDR_WIDTH]) overflow <= 1'b1;
          else waddr <= waddr + 1'b1;
        end
        default: ws <= W_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      ss <= S_IDLE;
      rbuf <= 1'b0;
      frame_count <= '0;
      dvo <= 1'b0;
      dtypeo <= '0;
      datao <= '0;
      meta_datao <= '0;
      cols <= '0;
      rows <= '0;
      row <= '0;
      col <= '0;
      rptr <= '0;
      blank <= '0;
    end else if (!enable) begin
      ss <= S_IDLE;
      rbuf <= 1'b0;
      dvo <= 1'b0;
      dtypeo <= '0;
      datao <= '0;
      meta_datao <= '0;
    end else begin
      dvo <= 1'b0;
      dtypeo <= '0;
      datao <= '0;
      meta_datao <= '0;
      case (ss)
        S_IDLE: if (full[rbuf]) ss <= S_FS;
        S_FS: begin
          dvo <= 1'b1;
          dtypeo <= DTYPE_FRAME_START;
          meta_datao <= STREAM_DATA_WIDTH'(frame_count);
          cols <= num_cols & 16'hfffe;
          rows <= num_rows;
          row <= '0;
          rptr <= '0;
          ss <= (num_rows == 16'd0 || (num_cols & 16'hfffe) == 16'd0) ? S_FE : S_RS;
        end
        S_RS: begin
          dvo <= 1'b1;
          dtypeo <= DTYPE_ROW_START;
          meta_datao <= STREAM_DATA_WIDTH'(row);
          col <= '0;
          ss <= S_PIX;
        end
        S_PIX: begin
          dvo <= 1'b1;
          dtypeo <= DTYPE_PIXEL;
          datao <= pix;
          col <= col + 16'd1;
          if (col[0]) rptr <= rptr + 32'd1;
          if (col == cols - 16'd1) ss <= S_RE;
        end
        S_RE: begin
          dvo <= 1'b1;
          dtypeo <= DTYPE_ROW_END;
          meta_datao <= STREAM_DATA_WIDTH'(row);
          row <= row + 16'd1;
          ss <= row == rows - 16'd1 ? S_FE : S_RS;
        end
        S_FE: begin
          dvo <= 1'b1;
          dtypeo <= DTYPE_FRAME_END;
          meta_datao <= STREAM_DATA_WIDTH'(frame_count);
          frame_count <= frame_count + 16'd1;
          rbuf <= !rbuf;
          blank <= '0;
          ss <= S_BLANK;
        end
        S_BLANK: begin
          blank <= blank + 16'd1;
          if (blank == 16'(BLANK_CYCLES - 1)) ss <= S_IDLE;
        end
        default: ss <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_di2stream.sv
// tb_di2stream: directed frames against hand-computed beat sequences
module tb_di2stream;
  import di2stream_pkg::*;
  localparam int AW = 2;
  localparam int BLANK = 4;
  logic clk = 0, resetb = 0, enable = 1;
  logic [15:0] num_cols = 4, num_rows = 2;
  logic di_write_mode = 0, di_write = 0;
  logic [31:0] di_reg_datai = 0;
  logic di_write_rdy, overflow, dvo;
  logic [DTYPE_WIDTH-1:0] dtypeo;
  logic [9:0] datao;
  logic [15:0] meta_datao, frame_count;
  int checks = 0, failures = 0, cyc = 0;
  logic [35:0] beats[$];
  int stamps[$];
  logic [31:0] words[8];
  logic [9:0] px[16];
  di2stream #(.ADDR_WIDTH(AW), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .num_cols(num_cols), .num_rows(num_rows),
    .di_write_mode(di_write_mode), .di_write(di_write), .di_reg_datai(di_reg_datai),
    .di_write_rdy(di_write_rdy), .overflow(overflow), .dvo(dvo), .dtypeo(dtypeo),
    .datao(datao), .meta_datao(meta_datao), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (dvo) begin
    beats.push_back({dtypeo, meta_datao, 6'b0, datao});
    stamps.push_back(cyc);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [35:0] bt(input logic [3:0] t, input int m, input int d);
    return {t, 16'(m), 16'(d)};
  endfunction
  function automatic logic [35:0] get(input int j);
    return j < beats.size() ? beats[j] : '1;
  endfunction
  function automatic int stamp(input int j);
    return j < stamps.size() ? stamps[j] : -1;
  endfunction
  task automatic fill(input int b, input int n);
    for (int i = 0; i < 8; i++) words[i] = {16'(b + 2 * i + 2), 16'(b + 2 * i + 1)};
    for (int k = 0; k < 16; k++) px[k] = k < 2 * n ? 10'(b + k + 1) : 10'd0;
  endtask
  task automatic write_words(input int n);
    for (int i = 0; i < n; i++) begin
      di_write = 1;
      di_reg_datai = words[i];
      @(negedge clk);
    end
    di_write = 0;
    di_write_mode = 0;
  endtask
  task automatic write_frame(input int n);
    int k = 0;
    @(negedge clk);
    di_write_mode = 1;
    while (!di_write_rdy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("wr_rdy", di_write_rdy, 1);
    write_words(n);
  endtask
  task automatic wait_beats(input int n);
    int k = 0;
    while (beats.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("beat_count", beats.size(), n);
  endtask
  task automatic wait_pix(input string tag);
    int k = 0;
    while (!(dvo && dtypeo == DTYPE_PIXEL) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(tag, dvo && dtypeo == DTYPE_PIXEL, 1);
  endtask
  task automatic check_frame(input string tag, input int base, input int fm, input int rows, input int cols);
    int j = base;
    check({tag, "_fs"}, get(j++), bt(DTYPE_FRAME_START, fm, 0));
    for (int r = 0; r < rows; r++) begin
      check({tag, "_rs"}, get(j++), bt(DTYPE_ROW_START, r, 0));
      for (int c = 0; c < cols; c++) check({tag, "_pix"}, get(j++), bt(DTYPE_PIXEL, 0, px[r * cols + c]));
      check({tag, "_re"}, get(j++), bt(DTYPE_ROW_END, r, 0));
    end
    check({tag, "_fe"}, get(j), bt(DTYPE_FRAME_END, fm, 0));
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_dvo"}, dvo, 0);
    check({tag, "_dtype"}, dtypeo, 0);
    check({tag, "_data"}, datao, 0);
    check({tag, "_meta"}, meta_datao, 0);
    check({tag, "_fc"}, frame_count, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_rdy"}, di_write_rdy, 0);
  endtask
  initial begin
    int c0, n, rc;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    resetb = 1;
    @(negedge clk);
    // basic 4x2 frame
    beats.delete();
    stamps.delete();
    fill(0, 4);
    write_frame(4);
    c0 = cyc;
    wait_beats(14);
    check_frame("basic", 0, 0, 2, 4);
    check("basic_latency", stamp(0), c0 + 3);
    check("basic_fc", frame_count, 1);
    repeat (4) begin
      @(negedge clk);
      check("basic_blank", dvo, 0);
    end
    repeat (4) @(negedge clk);
    // short write, odd num_cols treated as even
    num_cols = 5;
    beats.delete();
    fill(0, 2);
    write_frame(2);
    wait_beats(14);
    check_frame("short", 0, 1, 2, 4);
    num_cols = 4;
    repeat (10) @(negedge clk);
    // overflow: six words into a four-word bank, pixels truncated to 10 bits
    check("ovf_before", overflow, 0);
    beats.delete();
    fill(16, 4);
    words[0] = 32'h87ff_0411;
    px[0] = 10'h011;
    px[1] = 10'h3ff;
    write_frame(6);
    check("ovf_after", overflow, 1);
    wait_beats(14);
    check_frame("ovf", 0, 2, 2, 4);
    repeat (10) @(negedge clk);
    // zero rows: FS then FE only
    num_rows = 0;
    beats.delete();
    fill(0, 1);
    write_frame(1);
    wait_beats(2);
    check_frame("rows0", 0, 3, 0, 4);
    repeat (10) @(negedge clk);
    check("rows0_len", beats.size(), 2);
    num_rows = 2;
    // abort by enable
    beats.delete();
    fill(0, 4);
    write_frame(4);
    wait_pix("abort_pix");
    enable = 0;
    @(negedge clk);
    check("abort_dvo", dvo, 0);
    check("abort_dtype", dtypeo, 0);
    @(negedge clk);
    enable = 1;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      n += int'(dvo);
    end
    check("abort_quiet", n, 0);
    check("abort_fc", frame_count, 4);
    check("abort_ovf_kept", overflow, 1);
    // async reset mid-frame
    fill(0, 4);
    write_frame(4);
    wait_pix("areset_pix");
    #2 resetb = 0;
    #1 check_idle_outputs("areset");
    @(negedge clk);
    resetb = 1;
    @(negedge clk);
    // ping-pong: A streams while B is written, C waits for A's bank
    beats.delete();
    stamps.delete();
    fill(0, 4);
    write_frame(4);
    fill(16, 4);
    write_frame(4);
    @(negedge clk);
    di_write_mode = 1;
    n = 0;
    while (!di_write_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    rc = cyc;
    check("pp_rdy_after_fe", rc, stamp(13) + 1);
    fill(32, 4);
    write_words(4);
    wait_beats(42);
    fill(0, 4);
    check_frame("ppA", 0, 0, 2, 4);
    fill(16, 4);
    check_frame("ppB", 14, 1, 2, 4);
    fill(32, 4);
    check_frame("ppC", 28, 2, 2, 4);
    check("pp_gap", stamp(14) - stamp(13) > BLANK, 1);
    check("pp_fc", frame_count, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
